pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order pipelined core; sits beside the ID/EX/MEM/WB registers.
//  Tracks in-flight destination regs from EX to last stage, raises load-use stall, selects forwarding source per EX operand.
//  Handles taken-branch flush and keeps saturating stall/flush counters.
//  Generalises fixed 2-operand, 3-stage, 1-cycle-load forwarding to NUM_SRC operands, DEPTH stages, LOAD_RDY.
// PARAMETERS
//  NUM_SRC   2  source operands per instruction
//  REG_AW    5  register address width; x0 (addr 0) never hazards
//  DEPTH     3  tracked stages after ID: 0=EX, 1=MEM, ..., DEPTH-1=WB; legal 2..8
//  LOAD_RDY  2  stage where load data becomes forwardable; legal 1..DEPTH-1
//  CNT_W     16 width of performance counters
//  FWD_W     $clog2(DEPTH) (localparam) forward-select width
// PORTS
//  clk           in   1               clock, rising edge
//  reset         in   1               synchronous, active-low reset
//  id_valid      in   1               ID stage holds a real instruction
//  id_rs         in   NUM_SRC*REG_AW  ID source regs, operand s at [s*REG_AW +: REG_AW]
//  id_rs_used    in   NUM_SRC         operand s actually read
//  id_rd         in   REG_AW          ID destination
//  id_reg_write  in   1               ID instr writes rd
//  id_mem_read   in   1               ID instr is a load
//  ex_flush      in   1               branch in EX resolved taken
//  hz_stall      out  1               hold PC and IF/ID this cycle
//  hz_bubble     out  1               load NOP into ID/EX this cycle
//  fwd_sel       out  NUM_SRC*FWD_W   per EX operand: 0=regfile/ID/EX value, k=result of stage k
//  ex_valid      out  1               EX stage holds real instruction
//  stall_cnt     out  CNT_W           saturating count of stall cycles
//  flush_cnt     out  CNT_W           saturating count of flush cycles
// BEHAVIOUR
//  State: per stage k an entry {v, rd, wr, ld}; EX entry also holds NUM_SRC regs+used bits.
//  Every edge: entry k -> k+1; entry DEPTH-1 retires. Stage 0 loads ID fields, or invalid if hz_bubble.
//  Entry "hazards" iff v & wr & rd!=0. ready(k) = k >= (ld ? LOAD_RDY : 1).
//  hz_stall (comb) = reset & id_valid & ~ex_flush & some used s whose youngest matching hazarding entry k < DEPTH-1 has !ready(k+1).
//  Entries at DEPTH-1 are written to regfile that edge (write-before-read); never stall.
//  hz_bubble = hz_stall | ex_flush. Flush beats stall: hz_stall=0, stall_cnt not incremented.
//  fwd_sel[s] (comb from regs) = smallest k in 1..DEPTH-1 with used, match, hazard, ready(k); else 0.
//  Youngest producer wins on multiple matches; x0 gives 0. Unused operand gives 0.
//  ex_valid = stage-0 v. Counters +1 per hz_stall / ex_flush cycle; hold at 2^CNT_W-1.
//  Reset (reset==0 at edge): all v=0, counters=0. While reset low, hz_stall=hz_bubble=0, fwd_sel=0.
//  Reset mid-stall: next cycle all entries invalid, so no stall from pre-reset producers.
//  Latency: stall/bubble/fwd_sel combinational, same cycle; tracking updates at edge.
// TESTING
//  ALU chain: add x5 then sub x6,x5,x7 next cycle -> no stall; second in EX: fwd_sel[0]=1, [1]=0.
//  Load-use: ld x5 then add x6,x5,x5 -> hz_stall=1 one cycle, stall_cnt 0->1; then fwd_sel[0]=[1]=2.
//  Load gap 1: ld x5, nop, add x6,x5,x0 -> no stall; add in EX: fwd_sel[0]=2, fwd_sel[1]=0 (x0).
//  Youngest wins: add x5; add x5; add x7,x5,x5 -> fwd_sel[0]=1, not 2.
//  Stall+flush same cycle (ld x5 in EX, ex_flush=1) -> hz_stall=0, hz_bubble=1, flush_cnt=1, ex_valid=0 next.
//  Reset low during stall -> next cycle ex_valid=0, counters 0. Also DEPTH=5, LOAD_RDY=3: ld→use stalls 2 cycles.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: tracks in-flight destinations from EX to the last stage,
// raises the load-use stall, picks a forwarding source per EX operand, and
// inserts the branch-flush bubble. Also keeps saturating stall/flush counters.
module pipe_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 16,
  localparam int FWD_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_flush,
  output logic                      hz_stall,
  output logic                      hz_bubble,
  output logic [NUM_SRC*FWD_W-1:0]  fwd_sel,
  output logic                      ex_valid,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  // Per-stage tracking: index 0 is EX, DEPTH-1 is the writeback stage.
  logic [DEPTH-1:0]               v_q, wr_q, ld_q;
  logic [DEPTH-1:0][REG_AW-1:0]   rd_q;
  logic [NUM_SRC-1:0][REG_AW-1:0] ex_rs_q;
  logic [NUM_SRC-1:0]             ex_used_q;
  logic [CNT_W-1:0]               stall_cnt_q, flush_cnt_q;

  logic [DEPTH-1:0] hazard;
  logic             stall_hit;
  logic             issue_ok;

  // A producer's result can be forwarded from stage k once its latency is met.
  function automatic logic ready(input int k, input logic ld);
    return ld ? (k >= LOAD_RDY) : (k >= 1);
  endfunction

  // Entries that will really write a register other than x0.
  always_comb begin
    hazard = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hazard[k] = v_q[k] & wr_q[k] & (rd_q[k] != '0);
    end
  end

  // Only the youngest producer of each ID operand matters; stall if it will
  // not be forwardable when the consumer reaches EX. The last stage writes
  // the regfile this edge and is read back directly, so it never stalls.
  always_comb begin
    logic found;
    stall_hit = 1'b0;
    found     = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && id_rs_used[s] && hazard[k] &&
            (rd_q[k] == id_rs[s*REG_AW +: REG_AW])) begin
          found = 1'b1;
          if ((k < DEPTH-1) && !ready(k+1, ld_q[k])) stall_hit = 1'b1;
        end
      end
    end
  end

  // A taken branch squashes the ID instruction, so it overrides the stall.
  always_comb begin
    hz_stall  = reset & id_valid & ~ex_flush & stall_hit;
    hz_bubble = hz_stall | (reset & ex_flush);
    issue_ok  = id_valid & ~hz_bubble;
  end

  // Forward from the youngest ready producer; scanning old-to-young lets the
  // youngest overwrite the selection.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (reset && v_q[0] && ex_used_q[s] && hazard[k] &&
            (rd_q[k] == ex_rs_q[s]) && ready(k, ld_q[k])) begin
          fwd_sel[s*FWD_W +: FWD_W] = FWD_W'(k);
        end
      end
    end
  end

  // Advance the tracking pipe, load EX from ID (or a bubble), count events.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]  <= v_q[k-1];
        wr_q[k] <= wr_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      v_q[0]    <= issue_ok;
      wr_q[0]   <= id_reg_write;
      ld_q[0]   <= id_mem_read;
      rd_q[0]   <= id_rd;
      ex_rs_q   <= id_rs;
      ex_used_q <= issue_ok ? id_rs_used : '0;
      if (hz_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign ex_valid  = v_q[0];
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (DEPTH=3/LOAD_RDY=2 and
// DEPTH=5/LOAD_RDY=3 with 4-bit counters) share the same ID-side stimulus.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_reg_write, id_mem_read, ex_flush;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;

  logic        stall_a, bubble_a, exv_a;
  logic [3:0]  fwd_a;
  logic [15:0] scnt_a, fcnt_a;
  logic        stall_b, bubble_b, exv_b;
  logic [5:0]  fwd_b;
  logic [3:0]  scnt_b, fcnt_b;

  pipe_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .DEPTH(3), .LOAD_RDY(2), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .hz_stall(stall_a), .hz_bubble(bubble_a), .fwd_sel(fwd_a), .ex_valid(exv_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  pipe_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .DEPTH(5), .LOAD_RDY(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .hz_stall(stall_b), .hz_bubble(bubble_b), .fwd_sel(fwd_b), .ex_valid(exv_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  // Reference model: every instruction accepted into EX is logged by the edge
  // number it entered; its pipeline stage is simply its age in cycles.
  typedef struct packed {
    logic            v, wr, ld;
    logic [4:0]      rd;
    logic [1:0][4:0] rs;
    logic [1:0]      used;
  } ent_t;

  localparam int MAXE = 8192;
  ent_t issue [2][MAXE];
  int   last_rst [2];
  int   exp_sc [2], exp_fc [2];
  int   exp_stall [2];
  int   t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] obs_stall [2], obs_bub [2], obs_fwd [2], obs_exv [2], obs_sc [2], obs_fc [2];

  function automatic int dep(input int i);  return (i == 0) ? 3 : 5; endfunction
  function automatic int lrdy(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int fw(input int i);   return (i == 0) ? 2 : 3; endfunction
  function automatic int cmax(input int i); return (i == 0) ? 65535 : 15; endfunction
  function automatic int lat(input int i, input logic ld); return ld ? lrdy(i) : 1; endfunction

  // Instruction that entered EX 'age' cycles ago, if it is still live.
  function automatic bit live(input int i, input int age, output ent_t e);
    int ed;
    ed = t - age;
    e  = '0;
    if (ed < 1 || ed <= last_rst[i]) return 0;
    e = issue[i][ed];
    return e.v;
  endfunction

  function automatic int m_stall(input int i);
    ent_t e;
    int   st;
    st = 0;
    if (!reset || !id_valid || ex_flush) return 0;
    for (int s = 0; s < 2; s++) begin
      if (id_rs_used[s]) begin
        for (int age = 0; age < dep(i); age++) begin
          if (live(i, age, e) && e.wr && e.rd != 0 && e.rd == id_rs[s*5 +: 5]) begin
            if (age < dep(i) - 1 && age + 1 < lat(i, e.ld)) st = 1;
            break;
          end
        end
      end
    end
    return st;
  endfunction

  function automatic int m_fwd(input int i, input int s);
    ent_t ex, e;
    if (!reset) return 0;
    if (!live(i, 0, ex)) return 0;
    if (!ex.used[s]) return 0;
    for (int age = 1; age < dep(i); age++) begin
      if (live(i, age, e) && e.wr && e.rd != 0 && e.rd == ex.rs[s] && age >= lat(i, e.ld))
        return age;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, expv, t);
    end
  endtask

  // One clock: drive ID inputs, check both instances against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic cyc(input bit rst, input bit v, input int rd, input bit wr, input bit ld,
                     input int rs0, input bit u0, input int rs1, input bit u1, input bit fl);
    ent_t ex;
    string p;
    reset        = rst;
    id_valid     = v;
    id_rd        = 5'(rd);
    id_reg_write = wr;
    id_mem_read  = ld;
    id_rs        = {5'(rs1), 5'(rs0)};
    id_rs_used   = {u1, u0};
    ex_flush     = fl;
    @(negedge clk);
    obs_stall[0] = {31'b0, stall_a};  obs_stall[1] = {31'b0, stall_b};
    obs_bub[0]   = {31'b0, bubble_a}; obs_bub[1]   = {31'b0, bubble_b};
    obs_fwd[0]   = {28'b0, fwd_a};    obs_fwd[1]   = {26'b0, fwd_b};
    obs_exv[0]   = {31'b0, exv_a};    obs_exv[1]   = {31'b0, exv_b};
    obs_sc[0]    = {16'b0, scnt_a};   obs_sc[1]    = {28'b0, scnt_b};
    obs_fc[0]    = {16'b0, fcnt_a};   obs_fc[1]    = {28'b0, fcnt_b};
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "a." : "b.";
      exp_stall[i] = m_stall(i);
      chk({p, "hz_stall"},  obs_stall[i], 32'(exp_stall[i]));
      chk({p, "hz_bubble"}, obs_bub[i], 32'((exp_stall[i] != 0 || fl) && rst));
      chk({p, "fwd_sel"},   obs_fwd[i], 32'(m_fwd(i, 0) + (m_fwd(i, 1) << fw(i))));
      chk({p, "ex_valid"},  obs_exv[i], 32'(live(i, 0, ex)));
      chk({p, "stall_cnt"}, obs_sc[i], 32'(exp_sc[i]));
      chk({p, "flush_cnt"}, obs_fc[i], 32'(exp_fc[i]));
    end
    @(posedge clk);
    t++;
    for (int i = 0; i < 2; i++) begin
      ex = '0;
      if (!rst) begin
        last_rst[i] = t;
        exp_sc[i]   = 0;
        exp_fc[i]   = 0;
      end else begin
        if (v && exp_stall[i] == 0 && !fl) begin
          ex.v = 1'b1; ex.rd = 5'(rd); ex.wr = wr; ex.ld = ld;
          ex.rs = {5'(rs1), 5'(rs0)}; ex.used = {u1, u0};
        end
        if (exp_stall[i] != 0 && exp_sc[i] < cmax(i)) exp_sc[i]++;
        if (fl && exp_fc[i] < cmax(i)) exp_fc[i]++;
      end
      issue[i][t] = ex;
    end
    #1;
  endtask

  task automatic nop();                          cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic gap();                          repeat (5) nop();                  endtask
  task automatic alu(input int rd, input int a, input int b); cyc(1, 1, rd, 1, 0, a, 1, b, 1, 0); endtask
  task automatic ldw(input int rd, input int a); cyc(1, 1, rd, 1, 1, a, 1, 0, 0, 0); endtask

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_rs = '0; id_rs_used = '0; ex_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin last_rst[i] = 2; exp_sc[i] = 0; exp_fc[i] = 0; end
    repeat (2) @(posedge clk);
    t = 2;
    #1;

    // Outputs held quiet while reset is low.
    cyc(0, 1, 5, 1, 1, 5, 1, 5, 1, 0);
    chk("rst_stall", obs_stall[0], 0);
    chk("rst_cnt", obs_sc[0], 0);
    nop();
    chk("rst_exv", obs_exv[0], 0);
    gap();

    // ALU chain forwards from stage 1 without stalling.
    alu(5, 1, 2); alu(6, 5, 7);
    chk("alu_nostall", obs_stall[0], 0);
    nop();
    chk("alu_fwd_a", obs_fwd[0], 1);
    chk("alu_fwd_b", obs_fwd[1], 1);
    gap();

    // Load-use: one stall on the short pipe, two on the deep one.
    ldw(5, 1); alu(6, 5, 5);
    chk("lu_stall", obs_stall[0], 1);
    chk("lu_bubble", obs_bub[0], 1);
    chk("lu_cnt0", obs_sc[0], 0);
    alu(6, 5, 5);
    chk("lu_release", obs_stall[0], 0);
    chk("lu_cnt1", obs_sc[0], 1);
    chk("lu_b_stall2", obs_stall[1], 1);
    alu(6, 5, 5);
    chk("lu_fwd_a", obs_fwd[0], 10);
    chk("lu_b_release", obs_stall[1], 0);
    chk("lu_b_cnt", obs_sc[1], 2);
    nop();
    chk("lu_fwd_b", obs_fwd[1], 27);
    gap();

    // Load with one slot of separation: no stall, x0 never forwards.
    ldw(5, 1); nop(); alu(6, 5, 0);
    chk("gap_nostall", obs_stall[0], 0);
    nop();
    chk("gap_fwd", obs_fwd[0], 2);
    gap();

    // Two producers of x5: the younger one is selected.
    alu(5, 1, 2); alu(5, 3, 4); alu(7, 5, 5); nop();
    chk("young_fwd", obs_fwd[0], 5);
    gap();

    // Flush beats stall in the same cycle.
    ldw(5, 1); cyc(1, 1, 6, 1, 0, 5, 1, 5, 1, 1);
    chk("fl_stall", obs_stall[0], 0);
    chk("fl_bubble", obs_bub[0], 1);
    nop();
    chk("fl_cnt", obs_fc[0], 1);
    chk("fl_exv", obs_exv[0], 0);
    gap();

    // Reset during a would-be stall wipes the producer and the counters.
    ldw(5, 1); cyc(0, 1, 6, 1, 0, 5, 1, 5, 1, 0);
    chk("rs_stall", obs_stall[0], 0);
    alu(6, 5, 5);
    chk("rs_exv", obs_exv[0], 0);
    chk("rs_nostall", obs_stall[0], 0);
    chk("rs_scnt", obs_sc[0], 0);
    chk("rs_fcnt", obs_fc[0], 0);
    chk("rs_exv_b", obs_exv[1], 0);

    // Random traffic over a small register pool so hazards are frequent.
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3), $urandom_range(0, 4) != 0,
          $urandom_range(0, 3), $urandom_range(0, 4) != 0,
          $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
